srl_chain_loader: RTL
=====================

// Module: srl_chain_loader
// PURPOSE
//  Reloads the contents of a cascade of NUM_SRL clock-enabled 16-bit shift-register LUTs
//  (SRL Q15 -> next SRL D) at run time. Serialises a parallel configuration word into the
//  chain head and captures the displaced old contents from the chain tail (swap readback).
//  Sits between a host/config register bank and the SRL cascade; the SRL primitives clock on CLK.
// PARAMETERS
//  NUM_SRL   4    number of 16-bit SRLs in the cascade (1..16)
//  TOTAL     16*NUM_SRL (derived localparam)   chain length in bits
//  CW        $clog2(TOTAL+1) (derived)   bit-counter width
// PORTS
//  CLK        in   1      clock, rising edge; same clock as the SRL cascade
//  RST_N      in   1      asynchronous reset, active-low
//  LOAD_REQ   in   1      request a load; sampled at a CLK edge while BUSY=0
//  LOAD_DATA  in   TOTAL  new chain contents; sampled with an accepted LOAD_REQ
//  HOLD       in   1      stall shifting while high
//  BUSY       out  1      load in progress (SHIFT or PAUSE)
//  DONE       out  1      one-cycle pulse: load complete, READ_DATA valid
//  READ_DATA  out  TOTAL  old chain contents displaced by the last load
//  SRL_D      out  1      serial data to chain head D
//  SRL_CE     out  1      shift enable to every SRL CE in the cascade
//  SRL_Q15    in   1      Q15 of the last SRL (chain tail)
// BEHAVIOUR
//  Reset (RST_N=0, asynchronous, any state): state=IDLE, BUSY=0, DONE=0, SRL_CE=0, SRL_D=0,
//   READ_DATA=0, counter=0. SRL_CE falls immediately; a partial load is abandoned, chain left
//   partially shifted (no recovery; host must reload).
//  All outputs registered. States: IDLE, SHIFT, PAUSE, DONE.
//  IDLE: LOAD_REQ=1 at edge t0 -> latch LOAD_DATA to shift reg, counter=TOTAL, go SHIFT
//   (or PAUSE if HOLD=1 at t0). LOAD_REQ while BUSY=1 is ignored, not queued.
//  SHIFT: SRL_CE=1; k-th enabled cycle (k=0..TOTAL-1) drives SRL_D=LOAD_DATA[TOTAL-1-k]
//   (MSB first) and samples SRL_Q15 into READ_DATA[TOTAL-1-k] at the closing edge (old bit,
//   before the SRL shifts). Counter decrements per enabled cycle. After the last enabled
//   cycle (counter reaches 0) -> DONE.
//  HOLD: sampled at each edge; HOLD=1 at edge n makes cycle n+1 a PAUSE cycle: SRL_CE=0,
//   SRL_D held, counter and shift reg frozen, no capture. HOLD=0 resumes SHIFT next cycle.
//   HOLD at the edge ending the last enabled cycle is ignored (-> DONE regardless).
//  DONE: one cycle; DONE=1, BUSY=0, SRL_CE=0 -> IDLE. LOAD_REQ sampled at the edge ending
//   the DONE cycle is accepted (back-to-back loads, one idle-CE cycle between loads).
//  Latency without HOLD: SRL_CE high cycles t0+1..t0+TOTAL; DONE in cycle t0+TOTAL+1.
//  BUSY=1 exactly while SRL_CE may be high (SHIFT/PAUSE). READ_DATA updates only during
//   SHIFT; stable from DONE until the next accepted load's first capture.
//  Result mapping: after load, LOAD_DATA[TOTAL-1] sits in SRL[NUM_SRL-1] bit 15,
//   LOAD_DATA[0] in SRL[0] bit 0. Readback uses the identical mapping for old contents.
//  Counter never wraps: loaded to TOTAL, decremented only while >0.
// TESTING
//  1 NUM_SRL=1, chain INIT=16'h0000, LOAD_DATA=16'hA5C3 -> CE high 16 cycles, DONE at t0+17,
//    READ_DATA=16'h0000; reload 16'h1234 -> READ_DATA=16'hA5C3, chain tap A=15..0 reads 1234.
//  2 NUM_SRL=4, load 64'h0123_4567_89AB_CDEF then 64'hFFFF_0000_FFFF_0000 -> second READ_DATA
//    =64'h0123_4567_89AB_CDEF; SRL3 bit15=1, SRL0 bit0=0.
//  3 HOLD high 5 cycles at k=7 -> CE low exactly 5 cycles, DONE at t0+TOTAL+6, contents
//    identical to unstalled run.
//  4 LOAD_REQ pulsed at k=3 with different LOAD_DATA -> ignored; result = first data; LOAD_REQ
//    held high across DONE -> second load starts, CE low exactly 1 cycle between loads.
//  5 RST_N low at k=10 -> SRL_CE,BUSY,DONE,READ_DATA=0 same cycle (async); after release, a
//    fresh load of 64'hDEAD_BEEF_CAFE_F00D completes normally and reads back on next load.
//  6 HOLD=1 at accepting edge and at last-enabled edge -> first cycle PAUSE; final HOLD ignored.

Source files
------------

// File: rtl/srl_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : srl_chain_loader
// Purpose  : Run-time reloader for a cascade of NUM_SRL clock-enabled 16-bit
//            shift-register LUTs. Serialises a parallel word into the chain
//            head (MSB first) and captures the displaced old contents from
//            the chain tail, so every load is also a swap readback.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        in   1      clock, shared with the SRL cascade
//   rst_n_i      in   1      asynchronous reset, active-low
//   load_req_i   in   1      load request, accepted while not busy
//   load_data_i  in   TOTAL  new chain contents, latched on acceptance
//   hold_i       in   1      stall shifting while high
//   busy_o       out  1      load in progress
//   done_o       out  1      one-cycle completion pulse, read_data_o valid
//   read_data_o  out  TOTAL  old chain contents displaced by the last load
//   srl_d_o      out  1      serial data to the chain head D
//   srl_ce_o     out  1      shift enable to every SRL CE
//   srl_q15_i    in   1      Q15 of the last SRL (chain tail)
// ============================================================================
module srl_chain_loader #(
  parameter  int NUM_SRL = 4,
  localparam int TOTAL   = 16 * NUM_SRL,
  localparam int CW      = $clog2(TOTAL + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_req_i,
  input  logic [TOTAL-1:0] load_data_i,
  input  logic             hold_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [TOTAL-1:0] read_data_o,
  output logic             srl_d_o,
  output logic             srl_ce_o,
  input  logic             srl_q15_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0] CNT_FULL = CW'(TOTAL);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TOTAL-1:0] sh_q, sh_d;
  logic [TOTAL-1:0] rd_q, rd_d;
  logic             ce_q, ce_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             last_bit;

  // A request is only honoured from IDLE or the DONE cycle; while busy it is dropped.
  assign accept   = load_req_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_bit = (cnt_q <= CNT_ONE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = hold_i ? S_PAUSE : S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // HOLD on the final enabled edge is deliberately ignored.
        if (last_bit) begin
          state_d = S_DONE;
        end else if (hold_i) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (!hold_i) begin
          state_d = S_SHIFT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: decoded from the next state so the flops present the
  // control outputs in the same cycle the FSM occupies that state.
  // --------------------------------------------------------------------------
  always_comb begin
    ce_d   = (state_d == S_SHIFT);
    busy_d = (state_d == S_SHIFT) || (state_d == S_PAUSE);
    done_d = (state_d == S_DONE);
  end

  // --------------------------------------------------------------------------
  // Datapath: the outgoing bit is always sh_q MSB. Q15 is sampled on the same
  // edge that shifts the SRLs, so it is the old tail bit; shifting it in at
  // the LSB leaves the first captured bit in the MSB after TOTAL captures.
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    rd_d  = rd_q;
    if (accept) begin
      cnt_d = CNT_FULL;
      sh_d  = load_data_i;
    end else if (state_q == S_SHIFT) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_ONE;
      end
      sh_d = {sh_q[TOTAL-2:0], 1'b0};
      rd_d = {rd_q[TOTAL-2:0], srl_q15_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      rd_q   <= '0;
      ce_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      rd_q   <= rd_d;
      ce_q   <= ce_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign read_data_o = rd_q;
  assign srl_d_o     = sh_q[TOTAL-1];
  assign srl_ce_o    = ce_q;

endmodule
`default_nettype wire
